// File: rtl/store_merge_rmw_if.sv
// rtl/store_merge_rmw_if.sv - store request and data-RAM port bundle for store_merge_rmw
interface store_merge_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;

  // master: the pipeline issuing stores plus the RAM answering reads
  modport master (
    output req_valid, req_addr, req_size, req_data, mem_rdata, mem_rvalid,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_rdata, mem_rvalid,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );
endinterface

// File: rtl/store_merge_rmw.sv
// rtl/store_merge_rmw.sv - word/half/byte store into a word-only RAM via read-modify-write
module store_merge_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  store_merge_rmw_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-3:0] addr_q;
  logic              half_q;
  logic [1:0]        off_q;
  logic [15:0]       data_q;
  logic [31:0]       wbuf;
  logic [31:0]       merged;
  logic              accept;
  logic              illegal;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    illegal = 1'b0;
    unique case (bus.req_size)
      2'b00:   illegal = (bus.req_addr[1:0] != 2'b00);
      2'b01:   illegal = bus.req_addr[0];
      2'b10:   illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (illegal)                    state_nxt = ERR;
          else if (bus.req_size == 2'b00) state_nxt = WR;
          else                            state_nxt = RD;
        end
      end
      RD:      if (bus.mem_rvalid) state_nxt = WR;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Untouched lanes pass through from the RAM word verbatim
  always_comb begin
    merged = bus.mem_rdata;
    if (half_q) begin
      if (off_q[1]) merged[31:16] = data_q;
      else          merged[15:0]  = data_q;
    end else begin
      unique case (off_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      half_q <= 1'b0;
      off_q  <= 2'b00;
      data_q <= 16'h0000;
      wbuf   <= 32'h0000_0000;
    end else if (accept) begin
      addr_q <= bus.req_addr[ADDR_W-1:2];
      half_q <= (bus.req_size == 2'b01);
      off_q  <= bus.req_addr[1:0];
      data_q <= bus.req_data[15:0];
      if (bus.req_size == 2'b00 && !illegal) wbuf <= bus.req_data;
    end else if (state == RD && bus.mem_rvalid) begin
      wbuf <= merged;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_re    = (state == RD);
  assign bus.mem_we    = (state == WR);
  assign bus.done      = (state == WR);
  assign bus.err       = (state == ERR);
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_wdata = wbuf;
endmodule

// File: tb/tb_store_merge_rmw.sv
// tb/tb_store_merge_rmw.sv - directed and random scoreboard bench for store_merge_rmw
module tb_store_merge_rmw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  store_merge_rmw_if #(.ADDR_W(32)) bus ();

  store_merge_rmw #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_w   [0:255];
  logic [31:0] ref_mem [0:255];
  int n_assert = 0;
  int n_fail   = 0;
  int k_lat    = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory with k-cycle read latency; rvalid is noise whenever mem_re is low
  always @(negedge clk) begin
    if (!rst_n || !bus.mem_re) begin
      rd_cnt         = 0;
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
    end else begin
      if (rd_cnt == k_lat) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_w[bus.mem_addr[9:2]];
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
      rd_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.mem_re) chk("re_we_overlap", 32'(bus.mem_we), 32'd0);
      if (bus.mem_we) begin
        done_cnt++;
        chk("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("write_kind", 32'(e.is_err), 32'd0);
          chk("write_addr", bus.mem_addr, e.addr);
          chk("write_data", bus.mem_wdata, e.data);
        end
        mem_w[bus.mem_addr[9:2]] = bus.mem_wdata;
      end
      if (bus.err) begin
        err_cnt++;
        chk("err_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("err_kind", 32'(e.is_err), 32'd1);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    exp_t        e;
    logic [31:0] mask;
    logic [4:0]  sh;
    logic        bad;
    bad = (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
    e.is_err = bad;
    e.addr   = {a[31:2], 2'b00};
    e.data   = 32'h0;
    if (!bad) begin
      sh   = {a[1:0], 3'b000};
      mask = (s == 2'b00) ? 32'hFFFF_FFFF :
             (s == 2'b01) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
      e.data = (ref_mem[a[9:2]] & ~mask) | ((d << sh) & mask);
      ref_mem[a[9:2]] = e.data;
    end
    sb.push_back(e);
  endtask

  // Returns 1 ns after the accept edge T, i.e. inside cycle T+1
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input int k);
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    k_lat         = k;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_size  = s;
    bus.req_data  = d;
    push_exp(a, s, d);
    accepted++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
    bus.req_data  = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(tag, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    int          r;
    int          nmis;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 2'b00;
    bus.req_data  = '0;
    bus.mem_rdata = '0;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_w[i]   = $urandom;
      ref_mem[i] = mem_w[i];
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // Word store
    issue(32'h100, 2'b00, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("sw_we", 32'(bus.mem_we), 32'd1);
    chk("sw_done", 32'(bus.done), 32'd1);
    chk("sw_re", 32'(bus.mem_re), 32'd0);
    chk("sw_addr", bus.mem_addr, 32'h100);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_ready_t2", 32'(bus.req_ready), 32'd1);
    chk("sw_we_t2", 32'(bus.mem_we), 32'd0);

    // Byte RMW, k=0
    mem_w[8'h80]   = 32'h1122_3344;
    ref_mem[8'h80] = 32'h1122_3344;
    issue(32'h202, 2'b10, 32'hFFFF_FFAA, 0);
    @(negedge clk);
    chk("sb_re_t1", 32'(bus.mem_re), 32'd1);
    chk("sb_addr_t1", bus.mem_addr, 32'h200);
    @(negedge clk);
    chk("sb_re_t2", 32'(bus.mem_re), 32'd0);
    chk("sb_we_t2", 32'(bus.mem_we), 32'd1);
    chk("sb_wdata", bus.mem_wdata, 32'h11AA_3344);
    @(negedge clk);
    chk("sb_ready_t3", 32'(bus.req_ready), 32'd1);

    // Halfword RMW, k=3
    mem_w[8'h81]   = 32'h1122_3344;
    ref_mem[8'h81] = 32'h1122_3344;
    issue(32'h206, 2'b01, 32'h0000_BEEF, 3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("sh_re_t%0d", c), 32'(bus.mem_re), 32'd1);
      chk($sformatf("sh_we_t%0d", c), 32'(bus.mem_we), 32'd0);
      chk($sformatf("sh_addr_t%0d", c), bus.mem_addr, 32'h204);
    end
    @(negedge clk);
    chk("sh_done_t5", 32'(bus.done), 32'd1);
    chk("sh_re_t5", 32'(bus.mem_re), 32'd0);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEF_3344);
    @(negedge clk);
    chk("sh_ready_t6", 32'(bus.req_ready), 32'd1);

    // Misaligned and illegal requests
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 32'h301 : 32'h302;
      s = (i == 0) ? 2'b01 : (i == 1) ? 2'b00 : 2'b11;
      issue(a, s, 32'h1234_5678, 0);
      @(negedge clk);
      chk($sformatf("err%0d_err_t1", i), 32'(bus.err), 32'd1);
      chk($sformatf("err%0d_re_t1", i), 32'(bus.mem_re), 32'd0);
      chk($sformatf("err%0d_we_t1", i), 32'(bus.mem_we), 32'd0);
      chk($sformatf("err%0d_ready_t1", i), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("err%0d_err_t2", i), 32'(bus.err), 32'd0);
      chk($sformatf("err%0d_ready_t2", i), 32'(bus.req_ready), 32'd1);
    end

    // Reset while a byte RMW waits in RD
    issue(32'h0C1, 2'b10, 32'h0000_0055, 5);
    @(negedge clk);
    chk("rstrd_re", 32'(bus.mem_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrd_ready", 32'(bus.req_ready), 32'd1);
    chk("rstrd_re_low", 32'(bus.mem_re), 32'd0);
    chk("rstrd_we_low", 32'(bus.mem_we), 32'd0);
    chk("rstrd_addr", bus.mem_addr, 32'h0);
    chk("rstrd_wdata", bus.mem_wdata, 32'h0);
    sb.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_w[i];
    accepted = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h108, 2'b00, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("post_rst_sw_we", 32'(bus.mem_we), 32'd1);
    chk("post_rst_sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    wait_idle("post_rst_idle");

    // Random sweep
    done_cnt = 0;
    err_cnt  = 0;
    accepted = 0;
    for (int n = 0; n < 1000; n++) begin
      r = $urandom_range(0, 9);
      s = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a = 32'($urandom_range(0, 1023));
      if (s == 2'b00 && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if (s == 2'b01 && $urandom_range(0, 7) != 0) a[0] = 1'b0;
      d = $urandom;
      issue(a, s, d, $urandom_range(0, 5));
    end
    wait_idle("sweep_idle");
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem_w[i] !== ref_mem[i]) nmis++;
    chk("final_mem_mismatches", 32'(nmis), 32'd0);
    chk("done_plus_err", 32'(done_cnt + err_cnt), 32'(accepted));
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
